pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Pipeline control for the 5-stage CN1 pipeline; drives load/clear of the IF/ID, ID/EX, EX/MEM stage registers and PC.
//  Detects load-use hazards, flushes on taken branch resolved in EX, and stalls for a multi-cycle MDU op in EX.
//  Small FSM plus latency counter; outputs are combinational from state + hazard inputs and feed the stage registers' load/clear pins.
// PARAMETERS
//  REG_W     5  register-index width
//  MDU_LAT   4  cycles an MDU op occupies EX (>=1; 1 = no stall)
//  CNT_W     32 perf counter width (PIPE_HAZARD_CTRL_PERF_EN only)
// PORTS
//  clock            in  1      rising-edge clock
//  reset_n          in  1      synchronous, active-low reset
//  id_rs, id_rt     in  REG_W  source regs of instr in ID
//  id_uses_rs/rt    in  1      ID instr reads rs / rt
//  ex_memread       in  1      instr in EX is a load
//  ex_rt            in  REG_W  load destination in EX
//  ex_branch_taken  in  1      branch in EX resolved taken
//  ex_mdu_start     in  1      MDU op entered EX this cycle (pulse)
//  pc_load          out 1      PC write enable
//  if_id_load/clear out 1      IF/ID register controls
//  id_ex_load/clear out 1      ID/EX register controls
//  ex_mem_load/clear out 1     EX/MEM register controls
//  mdu_busy         out 1      FSM in BUSY
// BEHAVIOUR
//  States: RUN, BUSY. Counter cnt (clog2(MDU_LAT) bits).
//  reset_n=0 at edge: state<=RUN, cnt<=0. While reset_n=0, outputs forced: all *_clear=1, all *_load=0, pc_load=0, mdu_busy=0.
//  RUN default: all loads=1, all clears=0.
//  Priority in RUN: branch > mdu_start > load-use.
//  Branch: ex_branch_taken=1 -> if_id_clear=1, id_ex_clear=1, pc_load=1 (redirect); one cycle, no state change; concurrent mdu_start/load-use ignored.
//  Load-use: ex_memread & ex_rt!=0 & ((id_uses_rs & ex_rt==id_rs)|(id_uses_rt & ex_rt==id_rt))
//   -> pc_load=0, if_id_load=0, id_ex_clear=1 (bubble), ex_mem normal. Exactly 1 stall cycle per hazard.
//  MDU: ex_mdu_start=1 in RUN, MDU_LAT>1 -> state<=BUSY, cnt<=MDU_LAT-2; this cycle already stalled:
//   pc_load=0, if_id_load=0, id_ex_load=0, ex_mem_clear=1.
//  BUSY: same stall outputs, mdu_busy=1; cnt decrements; at cnt==0 -> RUN next edge. Total stall = MDU_LAT-1 cycles.
//  BUSY ignores ex_branch_taken, ex_mdu_start, load-use (EX frozen). MDU_LAT=1: ex_mdu_start ignored.
//  Reset mid-BUSY: RUN, cnt=0, no residual stall.
//  *_load and *_clear of one stage never both 1 outside reset.
// CONFIGURATION
//  `PIPE_HAZARD_CTRL_PERF_EN defined: extra outputs stall_cnt, flush_cnt [CNT_W-1:0];
//   stall_cnt +1 every cycle pc_load=0 (not in reset), flush_cnt +1 per branch flush; both saturate at all-ones, reset to 0.
//  Undefined: ports and counters absent; control behaviour identical.
// STRUCTURE
//  pipe_pkg: state encoding (ST_RUN, ST_BUSY), REG_W default, CNT_W default.
//  One sub-module: sat_counter (CNT_W, inc, sync active-low reset) instantiated twice under the macro.
//  Hazard compare and output decode stay in this module.
// TESTING
//  Reset: reset_n=0 two cycles -> all clears=1, loads=0, mdu_busy=0; release -> RUN defaults.
//  Load-use: ex_memread=1, ex_rt=5, id_rs=5, id_uses_rs=1 -> one cycle pc_load=0, if_id_load=0, id_ex_clear=1; ex_rt=0 -> no stall.
//  Branch+hazard: ex_branch_taken=1 with load-use true -> if_id_clear=id_ex_clear=1, pc_load=1.
//  MDU: MDU_LAT=4, ex_mdu_start pulse -> 3 stall cycles (ex_mem_clear=1, mdu_busy=1 for last 2), then RUN.
//  Reset mid-BUSY: reset_n=0 at 2nd BUSY cycle -> next cycle after release RUN, no stall.
//  Perf (macro on, CNT_W=4): 20 stall cycles -> stall_cnt holds 15.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and defaults for the CN1 pipeline hazard controller.
package pipe_pkg;

    // Controller FSM states
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int unsigned REG_W_DEF = 5;
    localparam int unsigned CNT_W_DEF = 32;

    // Width of the MDU latency counter; at least one bit so that
    // MDU_LAT of 1 or 2 still elaborates a legal vector.
    function automatic int unsigned mdu_cnt_bits(input int unsigned lat);
        return (lat > 2) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count up on inc, hold at all-ones
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 5-stage CN1 pipeline: load-use stall, branch
// flush and multi-cycle MDU stall. Drives stage-register load/clear and PC.
// Optional feature: PIPE_HAZARD_CTRL_PERF_EN adds stall/flush perf counters.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned REG_W   = REG_W_DEF,
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_branch_taken,
    input  logic             ex_mdu_start,
    output logic             pc_load,
    output logic             if_id_load,
    output logic             if_id_clear,
    output logic             id_ex_load,
    output logic             id_ex_clear,
    output logic             ex_mem_load,
    output logic             ex_mem_clear,
    output logic             mdu_busy
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int unsigned CNT_BITS = mdu_cnt_bits(MDU_LAT);

    if (MDU_LAT < 1) begin : g_bad_lat
        $error("pipe_hazard_ctrl: MDU_LAT must be >= 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("pipe_hazard_ctrl: CNT_W must be >= 1");
    end

    state_t              state;
    state_t              state_next;
    logic [CNT_BITS-1:0] cnt;
    logic [CNT_BITS-1:0] cnt_next;

    logic load_use;
    logic mdu_take;

    // Load-use hazard: load in EX writes a nonzero reg that the ID instr reads
    always_comb begin
        load_use = ex_memread && (ex_rt != '0) &&
                   ((id_uses_rs && (ex_rt == id_rs)) ||
                    (id_uses_rt && (ex_rt == id_rt)));
        mdu_take = ex_mdu_start && (MDU_LAT > 1);
    end

    // State and latency counter register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic.
    // The start cycle is itself a stall cycle, so BUSY lasts MDU_LAT-2 cycles:
    // cnt is loaded with MDU_LAT-2 and BUSY exits on the edge where the
    // decremented count reaches 0, leaving cnt at 0 in RUN. MDU_LAT=2 needs
    // only the start-cycle stall and never enters BUSY.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            ST_RUN: begin
                if (!ex_branch_taken && ex_mdu_start && (MDU_LAT > 2)) begin
                    state_next = ST_BUSY;
                    cnt_next   = CNT_BITS'(MDU_LAT - 2);
                end
            end
            ST_BUSY: begin
                cnt_next = cnt - 1'b1;
                if (cnt <= CNT_BITS'(1)) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_RUN;
                cnt_next   = '0;
            end
        endcase
    end

    // Output decode: reset > BUSY > branch > MDU start > load-use > run
    always_comb begin
        pc_load      = 1'b1;
        if_id_load   = 1'b1;
        if_id_clear  = 1'b0;
        id_ex_load   = 1'b1;
        id_ex_clear  = 1'b0;
        ex_mem_load  = 1'b1;
        ex_mem_clear = 1'b0;
        mdu_busy     = 1'b0;
        if (!reset_n) begin
            pc_load      = 1'b0;
            if_id_load   = 1'b0;
            if_id_clear  = 1'b1;
            id_ex_load   = 1'b0;
            id_ex_clear  = 1'b1;
            ex_mem_load  = 1'b0;
            ex_mem_clear = 1'b1;
        end else if (state == ST_BUSY) begin
            pc_load      = 1'b0;
            if_id_load   = 1'b0;
            id_ex_load   = 1'b0;
            ex_mem_load  = 1'b0;
            ex_mem_clear = 1'b1;
            mdu_busy     = 1'b1;
        end else if (ex_branch_taken) begin
            if_id_load   = 1'b0;
            if_id_clear  = 1'b1;
            id_ex_load   = 1'b0;
            id_ex_clear  = 1'b1;
        end else if (mdu_take) begin
            pc_load      = 1'b0;
            if_id_load   = 1'b0;
            id_ex_load   = 1'b0;
            ex_mem_load  = 1'b0;
            ex_mem_clear = 1'b1;
        end else if (load_use) begin
            pc_load      = 1'b0;
            if_id_load   = 1'b0;
            id_ex_load   = 1'b0;
            id_ex_clear  = 1'b1;
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic stall_inc;
    logic flush_inc;

    // Perf event strobes, suppressed during reset
    always_comb begin
        stall_inc = reset_n && !pc_load;
        flush_inc = reset_n && (state == ST_RUN) && ex_branch_taken;
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (stall_inc),
        .count   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (flush_inc),
        .count   (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MDU_LAT=4).
// Perf counter checks are included when PIPE_HAZARD_CTRL_PERF_EN is defined.
module tb_pipe_hazard_ctrl;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 4;

    // Expected vectors, bit order:
    // {pc_load, if_id_load, if_id_clear, id_ex_load, id_ex_clear, ex_mem_load, ex_mem_clear, mdu_busy}
    localparam logic [7:0] V_RESET = 8'b0010_1010;
    localparam logic [7:0] V_RUN   = 8'b1101_0100;
    localparam logic [7:0] V_LU    = 8'b0000_1100;
    localparam logic [7:0] V_BR    = 8'b1010_1100;
    localparam logic [7:0] V_MDUS  = 8'b0000_0010;
    localparam logic [7:0] V_BUSY  = 8'b0000_0011;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [REG_W-1:0] id_rs, id_rt, ex_rt;
    logic             id_uses_rs, id_uses_rt, ex_memread, ex_branch_taken, ex_mdu_start;
    logic             pc_load, if_id_load, if_id_clear, id_ex_load, id_ex_clear;
    logic             ex_mem_load, ex_mem_clear, mdu_busy;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

    int tests  = 0;
    int failed = 0;

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(
        .REG_W   (REG_W),
        .MDU_LAT (4),
        .CNT_W   (CNT_W)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .ex_memread      (ex_memread),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .ex_mdu_start    (ex_mdu_start),
        .pc_load         (pc_load),
        .if_id_load      (if_id_load),
        .if_id_clear     (if_id_clear),
        .id_ex_load      (id_ex_load),
        .id_ex_clear     (id_ex_clear),
        .ex_mem_load     (ex_mem_load),
        .ex_mem_clear    (ex_mem_clear),
        .mdu_busy        (mdu_busy)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        ,
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
`endif
    );

    // Advance to just after the next rising edge, where inputs are changed
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs = '0; id_rt = '0; ex_rt = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_memread = 1'b0;
        ex_branch_taken = 1'b0; ex_mdu_start = 1'b0;
    endtask

    // Let combinational outputs settle, then compare the whole control vector
    task automatic check(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        #2;
        obs = {pc_load, if_id_load, if_id_clear, id_ex_load, id_ex_clear,
               ex_mem_load, ex_mem_clear, mdu_busy};
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    task automatic check_cnt(input string tag, input logic [CNT_W-1:0] obs,
                             input logic [CNT_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
`endif

    initial begin
        // Reset held for two cycles
        idle_inputs();
        reset_n = 1'b0;
        check("reset_c0", V_RESET);
        next_cycle();
        check("reset_c1", V_RESET);
        next_cycle();
        reset_n = 1'b1;
        check("run_after_reset", V_RUN);

        // Load-use on rs: exactly one bubble, then back to normal
        next_cycle();
        ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
        check("loaduse_rs", V_LU);
        next_cycle();
        idle_inputs();
        check("loaduse_done", V_RUN);

        // Load-use on rt
        next_cycle();
        ex_memread = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1; id_rs = 5'd3; id_uses_rs = 1'b1;
        check("loaduse_rt", V_LU);

        // Load to r0 is never a hazard
        next_cycle();
        idle_inputs();
        ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        check("loaduse_r0", V_RUN);

        // Matching index but operand not used
        next_cycle();
        idle_inputs();
        ex_memread = 1'b1; ex_rt = 5'd7; id_rs = 5'd7; id_uses_rs = 1'b0;
        check("loaduse_unused", V_RUN);

        // Matching index but EX is not a load
        next_cycle();
        idle_inputs();
        ex_memread = 1'b0; ex_rt = 5'd7; id_rs = 5'd7; id_uses_rs = 1'b1;
        check("not_load", V_RUN);

        // Branch beats a concurrent load-use
        next_cycle();
        idle_inputs();
        ex_branch_taken = 1'b1; ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
        check("branch_over_loaduse", V_BR);

        // Branch beats a concurrent MDU start; no BUSY afterwards
        next_cycle();
        idle_inputs();
        ex_branch_taken = 1'b1; ex_mdu_start = 1'b1;
        check("branch_over_mdu", V_BR);
        next_cycle();
        idle_inputs();
        check("branch_no_busy", V_RUN);

        // MDU op with MDU_LAT=4: start cycle + 2 BUSY cycles, then RUN
        next_cycle();
        ex_mdu_start = 1'b1;
        check("mdu_start", V_MDUS);
        next_cycle();
        idle_inputs();
        ex_branch_taken = 1'b1; ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
        check("mdu_busy1_ignores", V_BUSY);
        next_cycle();
        idle_inputs();
        ex_mdu_start = 1'b1;
        check("mdu_busy2", V_BUSY);
        next_cycle();
        idle_inputs();
        check("mdu_done", V_RUN);

        // Reset asserted during the second BUSY cycle
        next_cycle();
        ex_mdu_start = 1'b1;
        check("mdu2_start", V_MDUS);
        next_cycle();
        idle_inputs();
        check("mdu2_busy1", V_BUSY);
        next_cycle();
        reset_n = 1'b0;
        check("mdu2_reset", V_RESET);
        next_cycle();
        reset_n = 1'b1;
        check("after_reset_run", V_RUN);
        next_cycle();
        check("after_reset_run2", V_RUN);

`ifdef PIPE_HAZARD_CTRL_PERF_EN
        // Fresh reset, then 20 stall cycles and 3 flushes
        next_cycle();
        reset_n = 1'b0;
        next_cycle();
        reset_n = 1'b1;
        #2;
        check_cnt("stall_cnt_reset", stall_cnt, 4'd0);
        check_cnt("flush_cnt_reset", flush_cnt, 4'd0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            idle_inputs();
            ex_branch_taken = 1'b1;
        end
        for (int i = 0; i < 20; i++) begin
            next_cycle();
            idle_inputs();
            ex_memread = 1'b1; ex_rt = 5'd4; id_rt = 5'd4; id_uses_rt = 1'b1;
        end
        next_cycle();
        idle_inputs();
        #2;
        check_cnt("stall_cnt_sat", stall_cnt, 4'd15);
        check_cnt("flush_cnt", flush_cnt, 4'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
